// File: rtl/uart_hram_bridge.sv
// UART command bridge to a simple memory port: frames of command + DATA_BYTES payload, MSB first.
// Optional inter-byte timeout on partial frames when BRIDGE_TIMEOUT_EN is defined.
module uart_hram_bridge #(
  parameter int              DATA_BYTES     = 4,
  parameter longint unsigned CONST_VALUE    = 259,
  parameter int unsigned     TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic [31:0]             mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wr_d,
  output logic                    mem_wr_req,
  output logic                    mem_rd_req,
  input  logic [8*DATA_BYTES-1:0] mem_rd_d,
  input  logic                    mem_rd_rdy,
  input  logic                    mem_busy
);

  localparam int W = 8 * DATA_BYTES;
  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_TX_SEND = 2'd2;
  localparam logic [1:0] ST_TX_WAIT = 2'd3;
  localparam logic [3:0]   FRAME_LAST = 4'(DATA_BYTES);
  localparam logic [3:0]   TX_LAST    = 4'(DATA_BYTES - 1);
  localparam logic [W-1:0] CONST_W    = W'(CONST_VALUE);

  logic [1:0]   state;
  logic [3:0]   rx_cnt;
  logic [3:0]   tx_cnt;
  logic         tx_low_seen;
  logic [7:0]   cmd;
  logic [W-1:0] payload;
  logic [W-1:0] frame_data;
  logic [W-1:0] resp;
  logic [W-1:0] rd_reg;
  logic [31:0]  counter;
  logic         overrun_flag;
  logic         timeout_flag;

  // Payload including the byte arriving this cycle; valid on the frame's final byte.
  assign frame_data = (payload << 8) | W'(rx_data);

  // Requests are combinational so they fire in the very cycle mem_busy drops.
  assign mem_wr_req = (state == ST_ISSUE) && !mem_busy && (cmd == 8'h03);
  assign mem_rd_req = (state == ST_ISSUE) && !mem_busy && (cmd == 8'h05);

`ifdef BRIDGE_TIMEOUT_EN
  logic [31:0] timer;
  logic        timeout_hit;

  assign timeout_hit = (state == ST_RX) && !rx_valid && (rx_cnt != 4'd0) &&
                       (timer == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state != ST_RX || rx_valid || rx_cnt == 4'd0 || timeout_hit)
      timer <= 32'd0;
    else
      timer <= timer + 32'd1;
  end
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RX;
      rx_cnt       <= 4'd0;
      tx_cnt       <= 4'd0;
      tx_low_seen  <= 1'b0;
      counter      <= 32'd0;
      overrun_flag <= 1'b0;
      rd_reg       <= '0;
      mem_addr     <= 32'd0;
      mem_wr_d     <= '0;
      tx_data      <= 8'd0;
      tx_start     <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      timeout_flag <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      if (mem_rd_rdy) rd_reg <= mem_rd_d;
      if (rx_valid && state != ST_RX) overrun_flag <= 1'b1;

      case (state)
        ST_RX: begin
          if (rx_valid) begin
            if (rx_cnt == 4'd0) begin
              cmd    <= rx_data;
              rx_cnt <= 4'd1;
            end else if (rx_cnt != FRAME_LAST) begin
              payload <= frame_data;
              rx_cnt  <= rx_cnt + 4'd1;
            end else begin
              rx_cnt <= 4'd0;
              tx_cnt <= 4'd0;
              state  <= ST_TX_SEND;
              case (cmd)
                8'h01: begin
                  mem_addr <= 32'(frame_data);
                  resp     <= frame_data;
                end
                8'h02: begin
                  mem_wr_d <= frame_data;
                  resp     <= frame_data;
                end
                8'h03, 8'h05: begin
                  resp  <= W'(cmd);
                  state <= ST_ISSUE;
                end
                8'h04: resp <= rd_reg;
                8'h06: begin
                  resp    <= W'(counter);
                  counter <= counter + 32'd1;
                end
                8'h07: resp <= CONST_W;
                8'h08: begin
                  resp         <= W'({timeout_flag, overrun_flag});
                  overrun_flag <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                  timeout_flag <= 1'b0;
`endif
                end
                default: resp <= W'(counter);
              endcase
            end
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            rx_cnt       <= 4'd0;
            timeout_flag <= 1'b1;
          end
`endif
        end
        ST_ISSUE: begin
          if (!mem_busy) state <= ST_TX_SEND;
        end
        ST_TX_SEND: begin
          if (tx_ready) begin
            tx_start    <= 1'b1;
            tx_data     <= resp[W-1 -: 8];
            tx_low_seen <= 1'b0;
            state       <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          // A byte is done only after the transmitter has gone busy and returned idle.
          if (!tx_ready) begin
            tx_low_seen <= 1'b1;
          end else if (tx_low_seen) begin
            resp <= resp << 8;
            if (tx_cnt == TX_LAST) begin
              state <= ST_RX;
            end else begin
              tx_cnt <= tx_cnt + 4'd1;
              state  <= ST_TX_SEND;
            end
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

endmodule

// File: doc/uart_hram_bridge.md
UART_HRAM_BRIDGE -- requirements
Module: uart_hram_bridge

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, giving the payload bytes per frame and per response (legal 1..8).
REQ-002 SHALL have parameter CONST_VALUE, default 259, giving the value returned by CONST, truncated to 8*DATA_BYTES bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the inter-byte timeout in clk cycles.
REQ-004 SHALL have ports: clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-005 SHALL have ports: rx_valid in 1 one-cycle received-byte strobe; rx_data in 8 received byte.
REQ-006 SHALL have ports: tx_start out 1 one-cycle send strobe; tx_data out 8 byte to send; tx_ready in 1 transmitter idle.
REQ-007 SHALL have ports: mem_addr out 32; mem_wr_d out 8*DATA_BYTES; mem_wr_req out 1; mem_rd_req out 1; mem_rd_d in 8*DATA_BYTES; mem_rd_rdy in 1; mem_busy in 1.
REQ-008 SHALL use a single clock (clk) with a synchronous active-high reset (reset), as already decided.

Function
REQ-009 SHALL assemble frames of 1 command byte followed by DATA_BYTES payload bytes, MSB first.
REQ-010 SHALL decode commands: 01 ADDR, 02 LOAD, 03 WRITE, 04 READ, 05 READ_REQ, 06 COUNT, 07 CONST, 08 STATUS.
REQ-011 SHALL implement the states RX -> (ISSUE) -> TX_SEND -> TX_WAIT -> RX.
REQ-012 SHALL on ADDR load mem_addr with the payload, truncated or zero-extended to 32 bits, and echo the payload.
REQ-013 SHALL on LOAD load mem_wr_d with the payload and echo it.
REQ-014 SHALL on WRITE or READ_REQ enter ISSUE, wait while mem_busy=1, then pulse mem_wr_req or mem_rd_req for exactly one cycle in the first cycle mem_busy=0, and respond with the command code zero-extended.
REQ-015 SHALL latch mem_rd_d into an internal read register on every cycle mem_rd_rdy=1, in any state.
REQ-016 SHALL on READ respond with the read register.
REQ-017 SHALL on COUNT respond with the counter value and then increment it; the counter is 32 bits, wraps to 0, and is truncated to the response width.
REQ-018 SHALL on CONST respond with CONST_VALUE.
REQ-019 SHALL on STATUS respond with {0..., timeout_flag, overrun_flag} and clear both flags in the same cycle.
REQ-020 SHALL on an unknown command respond with the counter value, without incrementing it.
REQ-021 SHALL send exactly DATA_BYTES response bytes, MSB first, with no extra byte.
REQ-022 SHALL in TX_SEND, when tx_ready=1, drive tx_start=1 for one cycle with tx_data valid in that same cycle.
REQ-023 SHALL in TX_WAIT wait for tx_ready to go low and then high, then advance to the next byte, or to RX after the last byte.
REQ-024 SHALL drop any rx_valid byte received outside the RX state and set the sticky overrun_flag.
REQ-025 SHALL hold mem_addr and mem_wr_d until they are rewritten.
REQ-026 SHALL ensure mem_wr_req and mem_rd_req are never high in the same cycle.

Reset
REQ-027 SHALL on reset go to state RX and clear the byte count, counter, flags, read register, mem_addr, mem_wr_d, tx_data, tx_start, mem_wr_req and mem_rd_req to 0.
REQ-028 SHALL on reset mid-frame, mid-ISSUE or mid-transmit abandon the operation, issue no request pulse, and send no further bytes.

Configuration
REQ-029 SHALL when BRIDGE_TIMEOUT_EN is defined, in RX with 1..DATA_BYTES bytes held, discard the partial frame and set the sticky timeout_flag after TIMEOUT_CYCLES cycles with no rx_valid; the timer restarts on every byte.
REQ-030 SHALL when BRIDGE_TIMEOUT_EN is undefined hold partial frames indefinitely, contain no timeout counter, and read timeout_flag as 0.

Verification
REQ-031 SHALL cover: frame 01 00 00 00 10 -> mem_addr=0x00000010; tx bytes 00 00 00 10, exactly 4 tx_start pulses.
REQ-032 SHALL cover: frame 02 DE AD BE EF then 03 00 00 00 00 with mem_busy=1 for 20 cycles -> a single mem_wr_req pulse in the first cycle mem_busy=0, mem_wr_d=0xDEADBEEF; response 00 00 00 03.
REQ-033 SHALL cover: frame 05 then mem_rd_rdy with mem_rd_d=0x12345678, then frame 04 -> response 12 34 56 78.
REQ-034 SHALL cover: three COUNT frames -> responses 0, 1, 2; counter preset to 0xFFFFFFFF -> responses FF FF FF FF, then 00 00 00 00.
REQ-035 SHALL cover: a byte injected during transmit, then STATUS -> response 00 00 00 01; a second STATUS -> 00 00 00 00.
REQ-036 SHALL cover, with BRIDGE_TIMEOUT_EN defined and TIMEOUT_CYCLES=100: send 2 bytes, idle 100 cycles, then frame 07 x4 -> response 00 00 01 03; a following STATUS -> 00 00 00 02.
